// File: rtl/sifh_pkg.sv
// -----------------------------------------------------------------------------
// sifh_pkg
// Shared definitions for the SiFH peak finder: default sizes, the result
// record carried through the output buffer, the per-pixel peak tracker and
// the controller state encoding.
// -----------------------------------------------------------------------------
package sifh_pkg;

  localparam int NB       = 6;        // bin index width
  localparam int BIN_NUM  = 2 ** NB;  // bins per pixel histogram
  localparam int CNT_W    = 8;        // bin count width
  localparam int PIX_NUM  = 16;       // pixels per frame
  localparam int PIX_W    = 8;        // pixel index width
  localparam int MIN_PEAK = 4;        // minimum peak count for a valid target

  // One result per pixel; field order fixes the packed layout in the FIFO.
  typedef struct packed {
    logic [PIX_W-1:0] pixel;
    logic [NB-1:0]    bin;
    logic [CNT_W-1:0] peak;
    logic [CNT_W-1:0] left;
    logic [CNT_W-1:0] right;
    logic             hit;
  } res_rec_t;

  localparam int REC_W = $bits(res_rec_t);

  // Running peak search state for the pixel currently streaming in.
  typedef struct packed {
    logic [CNT_W-1:0] max;
    logic [NB-1:0]    max_idx;
    logic [CNT_W-1:0] left;
    logic [CNT_W-1:0] right;
    logic [CNT_W-1:0] prev;
    logic             need_right;
  } tracker_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_STALL,
    ST_DONE
  } state_t;

  function automatic logic is_hit(input logic [CNT_W-1:0] peak);
    return peak >= CNT_W'(MIN_PEAK);
  endfunction

endpackage

// File: rtl/sifh_res_fifo.sv
// -----------------------------------------------------------------------------
// sifh_res_fifo
// Two-entry synchronous FIFO for result records. A push is taken when the
// FIFO is not full, or when it is full but the head is popped in the same
// cycle. The head entry is presented combinationally on dout.
//
// Ports:
//   clk    system clock
//   res    synchronous active-high reset (clears pointers and storage)
//   push   write din this cycle
//   pop    remove the head entry this cycle (ignored when empty)
//   din    record to write
//   dout   head record
//   full   two entries held
//   empty  no entries held
// -----------------------------------------------------------------------------
module sifh_res_fifo
  import sifh_pkg::*;
(
  input  logic             clk,
  input  logic             res,
  input  logic             push,
  input  logic             pop,
  input  logic [REC_W-1:0] din,
  output logic [REC_W-1:0] dout,
  output logic             full,
  output logic             empty
);

  logic [REC_W-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);
  assign do_pop  = pop && !empty;
  // When full, a same-cycle pop frees the slot the write pointer aims at.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (res) begin
      // NOTE: the storage itself is cleared, not just the pointers, because
      // the head drives the block outputs and those must read zero after reset.
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sifh_peak_finder.sv
// -----------------------------------------------------------------------------
// sifh_peak_finder
// Scans each pixel's histogram as it streams out of histogram RAM (bins in
// order 0..BIN_NUM-1), finds the first bin holding the maximum count and
// captures both neighbouring counts for sub-bin interpolation. One record per
// pixel goes into a 2-entry output buffer drained with valid/ready.
//
// Ports:
//   clk         system clock
//   res         synchronous active-high reset
//   start       begin a frame (accepted in IDLE only)
//   bin_valid   bin_count valid
//   bin_ready   block accepts a bin this cycle
//   bin_count   count of the current bin
//   res_valid   head record valid
//   res_ready   consumer takes the head record
//   res_pixel   pixel index of the head record
//   res_bin     peak bin index
//   res_peak    peak count
//   res_left    count of bin res_bin-1 (0 at bin 0)
//   res_right   count of bin res_bin+1 (0 at the last bin)
//   res_hit     res_peak >= MIN_PEAK
//   busy        frame in progress
//   frame_done  one-cycle pulse after the frame's last record is pushed
// -----------------------------------------------------------------------------
module sifh_peak_finder
  import sifh_pkg::*;
(
  input  logic             clk,
  input  logic             res,
  input  logic             start,
  input  logic             bin_valid,
  output logic             bin_ready,
  input  logic [CNT_W-1:0] bin_count,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [PIX_W-1:0] res_pixel,
  output logic [NB-1:0]    res_bin,
  output logic [CNT_W-1:0] res_peak,
  output logic [CNT_W-1:0] res_left,
  output logic [CNT_W-1:0] res_right,
  output logic             res_hit,
  output logic             busy,
  output logic             frame_done
);

  state_t           state;
  state_t           state_nxt;
  logic [NB-1:0]    bin_idx;
  logic [PIX_W-1:0] pix_idx;
  tracker_t         trk;
  tracker_t         trk_upd;
  tracker_t         rec_src;
  res_rec_t         rec;
  res_rec_t         head;
  logic [REC_W-1:0] rec_in;
  logic [REC_W-1:0] rec_out;
  logic             xfer;
  logic             last_bin;
  logic             last_pix;
  logic             push;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;

  assign xfer     = bin_valid && bin_ready;
  assign last_bin = (bin_idx == NB'(BIN_NUM - 1));
  assign last_pix = (pix_idx == PIX_W'(PIX_NUM - 1));
  assign pop      = res_valid && res_ready;

  // Tracker as it would stand after absorbing the current bin. The last bin's
  // record is built from this so its own update is included without a delay.
  always_comb begin
    trk_upd = trk;
    if (bin_idx == '0) begin
      trk_upd.max        = bin_count;
      trk_upd.max_idx    = '0;
      trk_upd.left       = '0;
      trk_upd.right      = '0;
      trk_upd.need_right = 1'b1;
    end else if (bin_count > trk.max) begin
      // Strictly greater: the first occurrence of the maximum is kept.
      trk_upd.max        = bin_count;
      trk_upd.max_idx    = bin_idx;
      trk_upd.left       = trk.prev;
      trk_upd.right      = '0;
      trk_upd.need_right = 1'b1;
    end else if (trk.need_right) begin
      trk_upd.right      = bin_count;
      trk_upd.need_right = 1'b0;
    end
    trk_upd.prev = bin_count;
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: every signal driven here gets a default before the case statement,
  // so no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_nxt  = state;
    bin_ready  = 1'b0;
    busy       = (state != ST_IDLE);
    frame_done = 1'b0;
    push       = 1'b0;
    rec_src    = trk;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = ST_SCAN;
      end
      ST_SCAN: begin
        bin_ready = 1'b1;
        rec_src   = trk_upd;
        if (xfer && last_bin) begin
          if (!fifo_full) begin
            push      = 1'b1;
            state_nxt = last_pix ? ST_DONE : ST_SCAN;
          end else begin
            state_nxt = ST_STALL;
          end
        end
      end
      ST_STALL: begin
        // The held tracker already includes the last bin.
        if (!fifo_full || pop) begin
          push      = 1'b1;
          state_nxt = last_pix ? ST_DONE : ST_SCAN;
        end
      end
      ST_DONE: begin
        frame_done = 1'b1;
        state_nxt  = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (res) begin
      bin_idx <= '0;
      pix_idx <= '0;
      trk     <= '0;
    end else if (state == ST_IDLE) begin
      if (start) begin
        bin_idx <= '0;
        pix_idx <= '0;
        trk     <= '0;
      end
    end else begin
      if (xfer) begin
        trk     <= trk_upd;
        bin_idx <= bin_idx + NB'(1);  // wraps to 0 after the last bin
      end
      // A push retires the pixel; the cleared tracker overrides any update.
      if (push) begin
        pix_idx <= pix_idx + PIX_W'(1);
        trk     <= '0;
      end
    end
  end

  always_comb begin
    rec.pixel = pix_idx;
    rec.bin   = rec_src.max_idx;
    rec.peak  = rec_src.max;
    rec.left  = rec_src.left;
    rec.right = rec_src.right;
    rec.hit   = is_hit(rec_src.max);
  end

  assign rec_in = rec;

  sifh_res_fifo u_res_fifo (
    .clk   (clk),
    .res   (res),
    .push  (push),
    .pop   (pop),
    .din   (rec_in),
    .dout  (rec_out),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign head      = res_rec_t'(rec_out);
  assign res_valid = !fifo_empty;
  assign res_pixel = head.pixel;
  assign res_bin   = head.bin;
  assign res_peak  = head.peak;
  assign res_left  = head.left;
  assign res_right = head.right;
  assign res_hit   = head.hit;

endmodule

// File: doc/sifh_peak_finder.md
Name: sifh_peak_finder

Overview:
- Downstream neighbour of the SiFH histogram-build FSM.
- Consumes the per-pixel histogram bin counts streamed out of histogram RAM after acquisition, in bin order 0..BIN_NUM-1 for each pixel.
- Finds each pixel's peak bin and captures the counts of the two neighbouring bins for downstream sub-bin interpolation.
- Pushes one result record per pixel into a 2-entry output buffer with a valid/ready handshake toward the depth readout.

Parameters:
- NB, 6: bin index width; BIN_NUM = 2**NB bins per pixel histogram.
- CNT_W, 8: bin count width (matches the histogram RAM data width).
- PIX_NUM, 16: pixels per histogram RAM (one frame).
- PIX_W, 8: pixel index width.
- MIN_PEAK, 4: minimum peak count for a valid target.

Ports:
- clk  in  1  system clock.
- res  in  1  reset, synchronous, active-high.
- start  in  1  one-cycle pulse that begins a frame; ignored unless in IDLE.
- bin_valid  in  1  bin_count is valid.
- bin_ready  out  1  block accepts a bin this cycle.
- bin_count  in  CNT_W  count of the current bin.
- res_valid  out  1  head of the output buffer is valid.
- res_ready  in  1  consumer accepts the head record.
- res_pixel  out  PIX_W  pixel index of the record.
- res_bin  out  NB  peak bin index.
- res_peak  out  CNT_W  peak count.
- res_left  out  CNT_W  count of bin res_bin-1 (0 if res_bin==0).
- res_right  out  CNT_W  count of bin res_bin+1 (0 if res_bin==BIN_NUM-1).
- res_hit  out  1  res_peak >= MIN_PEAK.
- busy  out  1  high from the cycle after an accepted start until DONE.
- frame_done  out  1  one-cycle pulse when the frame's last record is pushed.

Behaviour:
- Reset, synchronous, active-high. Takes priority over all other activity, including mid-frame:
  - state returns to IDLE; bin, pixel and output-buffer contents are cleared;
  - all outputs go to 0: bin_ready, res_valid, busy, frame_done and all res_* fields.
- Bin transfer occurs on bin_valid && bin_ready. The block keeps an internal bin index (NB bits) and pixel index (PIX_W bits); bins carry no index of their own.
- States:
  - IDLE: bin_ready=0. start -> SCAN, clearing the bin index, pixel index and tracker.
  - SCAN: bin_ready=1. On each transfer, update the tracker and increment the bin index.
    - On the transfer of bin BIN_NUM-1, push a record if the buffer has space.
    - If the buffer is full, go to STALL with the record held.
    - After a push: pixel index +1, bin index wraps to 0, tracker cleared. If this was pixel PIX_NUM-1 -> DONE.
  - STALL: bin_ready=0. Push as soon as a slot frees; a pop and a push in the same cycle are allowed. Then continue as at the end of SCAN.
  - DONE: frame_done=1 for one cycle, then -> IDLE. busy=0 in IDLE.
- Tracker per transfer (cnt = bin_count, idx = bin index):
  - On bin 0: max=cnt, max_idx=0, left=0, right=0, prev=cnt, and a one-bit "need right" flag is set.
  - Otherwise, if cnt > max (strictly greater, so the first occurrence wins ties): max=cnt, max_idx=idx, left=prev, right=0, need right flag set.
  - Otherwise, if the need right flag is set: right=cnt, flag cleared.
  - prev=cnt on every transfer.
  - A peak on the last bin leaves right=0.
- Record contents:
  - res_bin/res_peak/res_left/res_right: taken from the tracker, including the effect of the last bin's own update.
  - res_hit = (max >= MIN_PEAK).
- Latency: res_valid rises the cycle after the last bin of a pixel transfers, provided the buffer was not full.
- Output buffer:
  - 2-entry FIFO; the head drives the res_* outputs.
  - res_valid = not empty. Pop on res_valid && res_ready.
  - The head holds stable while res_valid && !res_ready.
- Width rules: counts are compared unsigned. The bin index wraps at BIN_NUM; no overflow is possible.

Decomposition:
- Shared package/header sifh_pkg: NB, CNT_W, PIX_NUM, PIX_W, MIN_PEAK defaults; a result-record struct {pixel, bin, peak, left, right, hit}; the state encoding.
- One sub-module is natural: sifh_res_fifo, a 2-deep synchronous FIFO of the record width with full/empty flags and same-cycle push/pop.

Test Plan:
- Single peak: pixel 0 bins all 1 except bin5=20, bin4=7, bin6=9; res_ready=1 -> record {pixel 0, bin 5, peak 20, left 7, right 9, hit 1} with res_valid one cycle after bin 63.
- Ties and edges:
  - bin0=30, bin1=12, bin40=30 -> bin 0, left 0, right 12 (first occurrence wins).
  - Peak only at bin63=50 -> bin 63, right 0.
- Threshold: all bins 3 -> bin 0, peak 3, hit 0. All bins 0 -> bin 0, peak 0, hit 0.
- Backpressure: res_ready=0 for a full frame of PIX_NUM=16 pixels.
  - Two records buffer; then STALL holds bin_ready=0.
  - Raising res_ready drains the records in pixel order 0..15 with none lost or duplicated.
  - frame_done pulses once.
- Throttled input: bin_valid toggled randomly -> identical records to the continuous case. start pulsed while busy is ignored.
- Reset mid-frame: assert res during pixel 3 bin 20 -> next cycle res_valid=0, bin_ready=0, busy=0. A new start then processes pixel 0 from bin 0 correctly.
